// File: rtl/pic.sv
// Memory-mapped programmable interrupt controller: edge-latched pending bits, per-line enable mask,
// priority vector and a registered interrupt request to the CPU.
module pic #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int unsigned NUM_IRQ   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [31:0]        a_bus,
  input  logic [31:0]        b_bus,
  output tri   [31:0]        result_bus,
  input  logic               mem_rd,
  input  logic               mem_wr,
  output logic               hwint
);

  localparam logic [1:0] RegPending = 2'd0;
  localparam logic [1:0] RegEnable  = 2'd1;
  localparam logic [1:0] RegClear   = 2'd2;
  localparam logic [1:0] RegVector  = 2'd3;

  logic               hit;
  logic               rd_en;
  logic               wr_en;
  logic [1:0]         sel;
  logic [NUM_IRQ-1:0] sync1_q;
  logic [NUM_IRQ-1:0] sync2_q;
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_d;
  logic [NUM_IRQ-1:0] enable_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] active;
  logic [4:0]         vec_idx;
  logic [31:0]        rdata;

  assign hit   = (a_bus[31:4] == BASE_ADDR[31:4]);
  assign sel   = a_bus[3:2];
  assign rd_en = mem_rd && !mem_wr && hit;
  assign wr_en = mem_wr && !mem_rd && hit;

  assign rise = sync2_q & ~prev_q;
  assign clr  = (wr_en && (sel == RegClear)) ? b_bus[NUM_IRQ-1:0] : '0;
  // A new edge overrides a simultaneous clear of the same line.
  assign pending_d = (pending_q & ~clr) | rise;
  assign active    = pending_q & enable_q;

  always_comb begin
    vec_idx = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (active[i]) vec_idx = 5'(i);
    end
  end

  always_comb begin
    rdata = '0;
    unique case (sel)
      RegPending: rdata = 32'(pending_q);
      RegEnable:  rdata = 32'(enable_q);
      RegClear:   rdata = '0;
      RegVector:  rdata = {|active, 26'd0, vec_idx};
      default:    rdata = '0;
    endcase
  end

  assign result_bus = rd_en ? rdata : 'z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      hwint     <= 1'b0;
    end else begin
      sync1_q   <= irq;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
      hwint     <= |active;
      if (wr_en && (sel == RegEnable)) enable_q <= b_bus[NUM_IRQ-1:0];
    end
  end

endmodule

// File: tb/tb_pic.sv
// Scoreboard bench for pic: driver pushes expected read data, monitor pops and compares it and
// checks hwint every cycle against a sample-history reference model.
module tb_pic;

  localparam logic [31:0] Base = 32'hFFFF_FF00;
  localparam int unsigned N    = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq;
  logic [31:0]  a_bus;
  logic [31:0]  b_bus;
  tri   [31:0]  result_bus;
  logic         mem_rd;
  logic         mem_wr;
  logic         hwint;

  pic #(.BASE_ADDR(Base), .NUM_IRQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .result_bus(result_bus),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .hwint     (hwint)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned fails   = 0;
  logic        chk     = 1'b0;
  logic [31:0] exp_q[$];

  // Reference model: pending is set at the edge where irq was sampled high two edges
  // earlier and low three edges earlier; samples taken during reset count as low.
  logic [N-1:0] m_pend, m_en, s1, s2, s3;
  logic         m_hw;

  always @(posedge clk or posedge rst) begin
    logic [N-1:0] p;
    logic         hit_w;
    if (rst) begin
      m_pend <= '0; m_en <= '0; s1 <= '0; s2 <= '0; s3 <= '0; m_hw <= 1'b0;
    end else begin
      hit_w = mem_wr && !mem_rd && (a_bus[31:4] == Base[31:4]);
      p = m_pend;
      if (hit_w && a_bus[3:2] == 2'd2) p = p & ~b_bus[N-1:0];
      p = p | (s2 & ~s3);
      m_hw   <= |(m_pend & m_en);
      m_pend <= p;
      if (hit_w && a_bus[3:2] == 2'd1) m_en <= b_bus[N-1:0];
      s1 <= irq; s2 <= s1; s3 <= s2;
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] sel);
    logic [N-1:0] act;
    logic [31:0]  v;
    act = m_pend & m_en;
    v   = '0;
    case (sel)
      2'd0: v = 32'(m_pend);
      2'd1: v = 32'(m_en);
      2'd3: begin
        for (int i = 0; i < int'(N); i++) begin
          if (act[i] && v[31] == 1'b0) v = 32'h8000_0000 | i;
        end
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Monitor: hwint every cycle, result_bus whenever the driver flags a transaction.
  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    vectors++;
    if (hwint !== m_hw) begin
      fails++;
      $display("FAIL hwint t=%0t got %b want %b", $time, hwint, m_hw);
    end
    if (chk) begin
      vectors++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty t=%0t got %h want <queued value>", $time, result_bus);
      end else begin
        e = exp_q.pop_front();
        if (result_bus !== e) begin
          fails++;
          $display("FAIL result_bus t=%0t addr %h got %h want %h", $time, a_bus, result_bus, e);
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    mem_rd = 1'b0; mem_wr = 1'b0; chk = 1'b0; a_bus = '0; b_bus = '0;
  endtask

  // One-cycle access; expected read data comes from the model unless given explicitly.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic use_exp = 1'b0,
                        input logic [31:0] exp_v = '0);
    logic hit;
    a_bus = addr; b_bus = data; mem_rd = rd; mem_wr = wr; chk = 1'b1;
    hit = (addr[31:4] == Base[31:4]);
    if (!(rd && !wr && hit)) exp_q.push_back('z);
    else if (use_exp)        exp_q.push_back(exp_v);
    else                     exp_q.push_back(model_read(addr[3:2]));
    cyc();
    idle();
  endtask

  task automatic rd_reg(input logic [1:0] r);
    access(1'b1, 1'b0, Base | {28'd0, r, 2'b00}, '0);
  endtask

  task automatic rd_exp(input logic [1:0] r, input logic [31:0] v);
    access(1'b1, 1'b0, Base | {28'd0, r, 2'b00}, '0, 1'b1, v);
  endtask

  task automatic wr_reg(input logic [1:0] r, input logic [31:0] d);
    access(1'b0, 1'b1, Base | {28'd0, r, 2'b00}, d);
  endtask

  task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, got, want);
    end
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] addr;
    int          op;
    rst = 1'b1; irq = '0; idle();
    cyc(2);
    rst = 1'b0;
    cyc();
    rd_exp(2'd0, 32'h0); rd_exp(2'd1, 32'h0); rd_exp(2'd2, 32'h0); rd_exp(2'd3, 32'h0);

    // Single-cycle pulse on line 2 with only line 2 enabled.
    wr_reg(2'd1, 32'h4);
    irq[2] = 1'b1; cyc(); irq[2] = 1'b0;
    cyc();
    rd_exp(2'd0, 32'h0);  // two edges after the pulse: not yet pending
    rd_exp(2'd0, 32'h4);
    cyc();
    rd_exp(2'd3, 32'h8000_0002);
    wr_reg(2'd2, 32'hFF); cyc(2);

    // Two simultaneous lines, lowest index wins, clear one at a time.
    wr_reg(2'd1, 32'hFF);
    irq = 8'h22; cyc(4);
    rd_exp(2'd3, 32'h8000_0001);
    wr_reg(2'd2, 32'h2);
    rd_exp(2'd3, 32'h8000_0005);
    wr_reg(2'd2, 32'h20);
    rd_exp(2'd3, 32'h0);
    irq = '0; cyc(3);

    // Latching is independent of ENABLE.
    wr_reg(2'd1, 32'h0);
    irq[3] = 1'b1; cyc(4);
    rd_exp(2'd0, 32'h8);
    wr_reg(2'd1, 32'h8); cyc(2);
    irq[3] = 1'b0;
    wr_reg(2'd2, 32'hFF); cyc(2);

    // Set beats a simultaneous clear.
    irq[0] = 1'b1; cyc(); irq[0] = 1'b0; cyc(4);
    irq[0] = 1'b1; cyc(2);
    wr_reg(2'd2, 32'h1);
    rd_exp(2'd0, 32'h1);
    irq[0] = 1'b0; wr_reg(2'd2, 32'hFF); cyc(2);

    // A level held high sets pending only once; a collided access does nothing.
    irq[7] = 1'b1; cyc(4);
    wr_reg(2'd2, 32'h80);
    cyc(16);
    rd_exp(2'd0, 32'h0);
    irq[7] = 1'b0;
    wr_reg(2'd1, 32'h3C);
    access(1'b1, 1'b1, Base | 32'h4, 32'hFF);
    rd_exp(2'd1, 32'h3C);

    // Asynchronous reset with everything pending, line 0 high through reset.
    wr_reg(2'd1, 32'hFF);
    irq = 8'hFF; cyc(); irq = 8'h01; cyc(4);
    rd_exp(2'd0, 32'hFF);
    a_bus = Base; mem_rd = 1'b1;
    #1 rst = 1'b1;
    #1;
    check_now("hwint_async_reset", {31'd0, hwint}, 32'h0);
    check_now("pending_async_reset", result_bus, 32'h0);
    idle();
    cyc(2);
    rst = 1'b0;
    cyc(2);
    rd_exp(2'd0, 32'h0);
    rd_exp(2'd0, 32'h1);
    irq = '0; wr_reg(2'd2, 32'hFF); cyc(2);

    // Edge in flight when reset hits is dropped.
    irq[4] = 1'b1; cyc();
    rst = 1'b1; cyc(); irq[4] = 1'b0; cyc();
    rst = 1'b0; cyc(5);
    rd_exp(2'd0, 32'h0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      for (int b = 0; b < int'(N); b++) begin
        if ($urandom_range(7) == 0) irq[b] = ~irq[b];
      end
      op   = int'($urandom_range(9));
      r    = 2'($urandom_range(3));
      addr = Base | {28'd0, r, 2'($urandom_range(3))};
      if ($urandom_range(9) == 0) addr = addr ^ 32'h0000_0100;
      case (op)
        0, 1, 2, 3: access(1'b1, 1'b0, addr, '0);
        4, 5:       access(1'b0, 1'b1, addr, $urandom);
        6:          access(1'b1, 1'b1, addr, $urandom);
        default:    cyc();
      endcase
    end

    idle(); cyc(2);
    check_now("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
